ex_iter_div: RTL

- Execute stage that consumes the decode stage's operation bundle: aluop, alusel, reg1, reg2, wd and wreg.
- Produces the register-write result for MEM.
- Returns the same result combinationally to decode as the EX forwarding source.
- Adds an iterative 32-cycle signed/unsigned divider with an FSM and a pipeline stall request.
- Divider writes the HI/LO pair.

---
 rtl/ex_iter_div.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_iter_div.sv
// Execute stage: single-cycle logic/shift ALU plus a 32-cycle iterative divider that writes HI/LO.
// Optional macro EX_MULT_EN adds single-cycle MULT/MULTU writing the 64-bit product to HI/LO.
module ex_iter_div #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
`ifdef EX_MULT_EN
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
`endif
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ZERO, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dsor_q, dsor_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        block_q, block_d;

  logic        is_div;
  logic        is_signed_div;
  logic        dvd_neg;
  logic        dsr_neg;
  logic [33:0] diff;
  logic        diff_unused;

  assign is_div        = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed_div = (aluop_i == OP_DIV);
  assign dvd_neg       = is_signed_div && reg1_i[31];
  assign dsr_neg       = is_signed_div && reg2_i[31];

  // Trial subtraction on the 33-bit shifted partial remainder; bit 33 is the borrow.
  assign diff        = {1'b0, rem_q, quot_q[31]} - {2'b00, dsor_q};
  assign diff_unused = diff[32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dsor_d  = dsor_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    block_d = block_q;
    if (flush_i) begin
      state_d = S_IDLE;
      block_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div && !block_q) begin
            if (reg2_i == 32'd0) begin
              state_d = S_ZERO;
            end else begin
              quot_d  = dvd_neg ? (32'd0 - reg1_i) : reg1_i;
              dsor_d  = dsr_neg ? (32'd0 - reg2_i) : reg2_i;
              rem_d   = 32'd0;
              negq_d  = dvd_neg ^ dsr_neg;
              negr_d  = dvd_neg;
              cnt_d   = 5'd0;
              state_d = S_BUSY;
            end
          end else if (!is_div) begin
            block_d = 1'b0;
          end
        end
        S_BUSY: begin
          if (!diff[33]) begin
            rem_d  = diff[31:0];
            quot_d = {quot_q[30:0], 1'b1};
          end else begin
            rem_d  = {rem_q[30:0], quot_q[31]};
            quot_d = {quot_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_CYCLES - 1)) begin
            state_d = S_DONE;
          end
        end
        default: begin
          // The divide is still on the inputs here; hold off until it leaves.
          state_d = S_IDLE;
          block_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quot_q  <= 32'd0;
      dsor_q  <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dsor_q  <= dsor_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      block_q <= block_d;
    end
  end

  logic [31:0] alu_res;

  always_comb begin
    alu_res = 32'd0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_OR:   alu_res = reg1_i | reg2_i;
          OP_AND:  alu_res = reg1_i & reg2_i;
          OP_XOR:  alu_res = reg1_i ^ reg2_i;
          OP_NOR:  alu_res = ~(reg1_i | reg2_i);
          default: alu_res = 32'd0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  alu_res = reg2_i << reg1_i[4:0];
          OP_SRL:  alu_res = reg2_i >> reg1_i[4:0];
          OP_SRA:  alu_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default: alu_res = 32'd0;
        endcase
      end
      default: alu_res = 32'd0;
    endcase
  end

`ifdef EX_MULT_EN
  logic [63:0] prod;

  always_comb begin
    prod = 64'd0;
    if (aluop_i == OP_MULT) begin
      prod = $unsigned($signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i}));
    end else if (aluop_i == OP_MULTU) begin
      prod = {32'd0, reg1_i} * {32'd0, reg2_i};
    end
  end
`endif

  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    whilo_o    = 1'b0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o    = wd_i;
      wreg_o  = wreg_i;
      wdata_o = alu_res;
      if (!flush_i) begin
        stallreq_o = (state_q == S_BUSY) || (state_q == S_IDLE && is_div && !block_q);
        if (state_q == S_DONE) begin
          whilo_o = 1'b1;
          lo_o    = negq_q ? (32'd0 - quot_q) : quot_q;
          hi_o    = negr_q ? (32'd0 - rem_q) : rem_q;
        end else if (state_q == S_ZERO) begin
          whilo_o = 1'b1;
`ifdef EX_MULT_EN
        end else if (aluop_i == OP_MULT || aluop_i == OP_MULTU) begin
          whilo_o = 1'b1;
          hi_o    = prod[63:32];
          lo_o    = prod[31:0];
`endif
        end
      end
    end
  end

endmodule
